// File: rtl/data_mem_responder.sv
// Data-memory responder for the multicycle RISC-V core.
// Serves one load or store at a time from a word-organised RAM, applying
// RV32I byte/half/word lane rules, with a fixed programmable access latency.
module data_mem_responder #(
    parameter int DEPTH   = 1024,
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic        DMR_Clk,
    input  logic        DMR_Reset,
    input  logic        DMR_Ready_In,
    input  logic        DMR_Valid_In,
    input  logic [31:0] DMR_Addr_InBUS,
    input  logic [31:0] DMR_Wdata_InBUS,
    input  logic [2:0]  DMR_Funct3_InBUS,
    output logic        DMR_Valid_Out,
    output logic        DMR_Ready_Out,
    output logic [31:0] DMR_Rdata_OutBUS,
    output logic        DMR_Error_Out,
    output logic [2:0]  DMR_Internal_State
);

    typedef enum logic [2:0] {
        IDLE    = 3'b000,
        LD_WAIT = 3'b001,
        LD_RESP = 3'b010,
        ST_WAIT = 3'b011,
        ST_RESP = 3'b100
    } state_t;

    // Counter preload; a zero latency skips the wait states entirely.
    localparam bit         ZERO_LAT = (LATENCY == 0);
    localparam logic [3:0] LAT_INIT = ZERO_LAT ? 4'd0 : 4'(LATENCY - 1);

    state_t              state, state_next;
    logic [3:0]          cnt, cnt_next;
    logic                latch;
    logic [ADDR_W+1:0]   addr_q;
    logic [31:0]         wdata_q;
    logic [2:0]          f3_q;
    logic [31:0]         mem [DEPTH];

    logic [ADDR_W+1:0]   acc_addr;
    logic [31:0]         acc_wdata;
    logic [2:0]          acc_f3;
    logic [ADDR_W-1:0]   idx;
    logic [31:0]         rd_word;
    logic                enter_ld, enter_st;
    logic                ld_err, st_err;
    logic [31:0]         regs_out_rdata;
    logic                addr_hi_unused;

    // Address bits above the RAM window are ignored so accesses wrap.
    assign addr_hi_unused = ^DMR_Addr_InBUS[31:ADDR_W+2];

    // Misaligned or illegal load encodings.
    function automatic logic load_error(input logic [2:0] f3, input logic [1:0] lane);
        case (f3)
            3'b000, 3'b100: load_error = 1'b0;
            3'b001, 3'b101: load_error = lane[0];
            3'b010:         load_error = (lane != 2'b00);
            default:        load_error = 1'b1;
        endcase
    endfunction

    // Misaligned or illegal store encodings.
    function automatic logic store_error(input logic [2:0] f3, input logic [1:0] lane);
        case (f3)
            3'b000:  store_error = 1'b0;
            3'b001:  store_error = lane[0];
            3'b010:  store_error = (lane != 2'b00);
            default: store_error = 1'b1;
        endcase
    endfunction

    // Select the addressed lane and sign/zero-extend it.
    function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [2:0] f3,
                                             input logic [1:0] lane);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  load_ext = {{24{b[7]}}, b};
            3'b100:  load_ext = {24'd0, b};
            3'b001:  load_ext = {{16{h[15]}}, h};
            3'b101:  load_ext = {16'd0, h};
            3'b010:  load_ext = word;
            default: load_ext = 32'd0;
        endcase
    endfunction

    // Merge the store lane into the old word, leaving other lanes intact.
    function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wd,
                                                input logic [2:0] f3, input logic [1:0] lane);
        logic [31:0] r;
        r = old;
        case (f3)
            3'b000: r[{lane, 3'b000} +: 8] = wd[7:0];
            3'b001: begin
                if (lane[1]) r[31:16] = wd[15:0];
                else         r[15:0]  = wd[15:0];
            end
            3'b010:  r = wd;
            default: r = old;
        endcase
        store_merge = r;
    endfunction

    // In IDLE the live inputs are used so a zero-latency access sees them on the accepting edge.
    always_comb begin
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        acc_f3    = f3_q;
        if (state == IDLE) begin
            acc_addr  = DMR_Addr_InBUS[ADDR_W+1:0];
            acc_wdata = DMR_Wdata_InBUS;
            acc_f3    = DMR_Funct3_InBUS;
        end
    end

    assign idx      = acc_addr[ADDR_W+1:2];
    assign rd_word  = mem[idx];
    assign ld_err   = load_error(acc_f3, acc_addr[1:0]);
    assign st_err   = store_error(acc_f3, acc_addr[1:0]);
    assign enter_ld = (state_next == LD_RESP);
    assign enter_st = (state_next == ST_RESP);
    assign regs_out_rdata = (enter_ld && !ld_err) ? load_ext(rd_word, acc_f3, acc_addr[1:0]) : 32'd0;

    // Next-state, wait counter and request latch decode.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        latch      = 1'b0;
        case (state)
            IDLE: begin
                if (DMR_Ready_In) begin
                    latch      = 1'b1;
                    cnt_next   = LAT_INIT;
                    state_next = ZERO_LAT ? LD_RESP : LD_WAIT;
                end else if (DMR_Valid_In) begin
                    latch      = 1'b1;
                    cnt_next   = LAT_INIT;
                    state_next = ZERO_LAT ? ST_RESP : ST_WAIT;
                end
            end
            LD_WAIT: begin
                if (cnt == 4'd0) state_next = LD_RESP;
                else             cnt_next   = cnt - 4'd1;
            end
            ST_WAIT: begin
                if (cnt == 4'd0) state_next = ST_RESP;
                else             cnt_next   = cnt - 4'd1;
            end
            LD_RESP: state_next = IDLE;
            ST_RESP: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State and wait-counter registers.
    always_ff @(posedge DMR_Clk) begin
        if (!DMR_Reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Capture the accepted request so later input changes are ignored.
    always_ff @(posedge DMR_Clk) begin
        if (latch) begin
            addr_q  <= DMR_Addr_InBUS[ADDR_W+1:0];
            wdata_q <= DMR_Wdata_InBUS;
            f3_q    <= DMR_Funct3_InBUS;
        end
    end

    // Registered response outputs; everything is zero outside a response cycle.
    always_ff @(posedge DMR_Clk) begin
        if (!DMR_Reset) begin
            DMR_Valid_Out    <= 1'b0;
            DMR_Ready_Out    <= 1'b0;
            DMR_Rdata_OutBUS <= 32'd0;
            DMR_Error_Out    <= 1'b0;
        end else begin
            DMR_Valid_Out    <= enter_ld;
            DMR_Ready_Out    <= enter_st;
            DMR_Rdata_OutBUS <= regs_out_rdata;
            DMR_Error_Out    <= (enter_ld && ld_err) || (enter_st && st_err);
        end
    end

    // RAM write on the edge entering ST_RESP; a reset on that edge aborts it.
    always_ff @(posedge DMR_Clk) begin
        if (DMR_Reset && enter_st && !st_err) begin
            mem[idx] <= store_merge(rd_word, acc_wdata, acc_f3, acc_addr[1:0]);
        end
    end

    assign DMR_Internal_State = state;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one LATENCY=2 instance and one LATENCY=0 instance.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        r0 = 1'b0, v0 = 1'b0, r1 = 1'b0, v1 = 1'b0;
    logic [31:0] addr = 32'd0, wdata = 32'd0;
    logic [2:0]  f3 = 3'd0;

    logic        valid0, ready0, err0, valid1, ready1, err1;
    logic [31:0] rdata0, rdata1;
    logic [2:0]  st0, st1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH(1024), .ADDR_W(10), .LATENCY(2)) dut0 (
        .DMR_Clk(clk), .DMR_Reset(rst), .DMR_Ready_In(r0), .DMR_Valid_In(v0),
        .DMR_Addr_InBUS(addr), .DMR_Wdata_InBUS(wdata), .DMR_Funct3_InBUS(f3),
        .DMR_Valid_Out(valid0), .DMR_Ready_Out(ready0), .DMR_Rdata_OutBUS(rdata0),
        .DMR_Error_Out(err0), .DMR_Internal_State(st0)
    );

    data_mem_responder #(.DEPTH(1024), .ADDR_W(10), .LATENCY(0)) dut1 (
        .DMR_Clk(clk), .DMR_Reset(rst), .DMR_Ready_In(r1), .DMR_Valid_In(v1),
        .DMR_Addr_InBUS(addr), .DMR_Wdata_InBUS(wdata), .DMR_Funct3_InBUS(f3),
        .DMR_Valid_Out(valid1), .DMR_Ready_Out(ready1), .DMR_Rdata_OutBUS(rdata1),
        .DMR_Error_Out(err1), .DMR_Internal_State(st1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    function automatic logic resp_of(input bit u, input bit ld);
        if (u) return ld ? valid1 : ready1;
        return ld ? valid0 : ready0;
    endfunction

    function automatic logic [31:0] rdata_of(input bit u);
        return u ? rdata1 : rdata0;
    endfunction

    function automatic logic err_of(input bit u);
        return u ? err1 : err0;
    endfunction

    task automatic set_req(input bit u, input bit ld, input logic val);
        if (u) begin
            if (ld) r1 = val; else v1 = val;
        end else begin
            if (ld) r0 = val; else v0 = val;
        end
    endtask

    // One complete transaction; the request is held through the response cycle.
    task automatic txn(input bit u, input bit ld, input logic [31:0] a, input logic [31:0] wd,
                       input logic [2:0] fn, input logic [31:0] exp_rd, input logic exp_err,
                       input string tag);
        int lat;
        lat = u ? 0 : 2;
        @(negedge clk);
        addr = a; wdata = wd; f3 = fn;
        set_req(u, ld, 1'b1);
        for (int c = 1; c <= lat; c++) begin
            @(negedge clk);
            if (c == lat) chk({tag, "_early"}, {31'd0, resp_of(u, ld)}, 32'd0);
        end
        @(negedge clk);
        chk({tag, "_pulse"}, {31'd0, resp_of(u, ld)}, 32'd1);
        chk({tag, "_rdata"}, rdata_of(u), exp_rd);
        chk({tag, "_err"},   {31'd0, err_of(u)}, {31'd0, exp_err});
        @(negedge clk);
        set_req(u, ld, 1'b0);
        chk({tag, "_after"}, {31'd0, resp_of(u, ld)}, 32'd0);
        chk({tag, "_rd0"},   rdata_of(u), 32'd0);
    endtask

    initial begin
        int pulses;

        // Reset
        repeat (3) @(negedge clk);
        chk("rst_state0", {29'd0, st0}, 32'd0);
        chk("rst_outs0", {28'd0, valid0, ready0, err0, |rdata0}, 32'd0);
        chk("rst_state1", {29'd0, st1}, 32'd0);
        rst = 1'b1;

        // Preload word 5, then full-word load
        txn(0, 0, 32'h14, 32'h8000_00F0, 3'b010, 32'd0, 1'b0, "sw_preload");
        txn(0, 1, 32'h14, 32'd0, 3'b010, 32'h8000_00F0, 1'b0, "lw_14");

        // Byte / half extension
        txn(0, 1, 32'h14, 32'd0, 3'b000, 32'hFFFF_FFF0, 1'b0, "lb_14");
        txn(0, 1, 32'h14, 32'd0, 3'b100, 32'h0000_00F0, 1'b0, "lbu_14");
        txn(0, 1, 32'h16, 32'd0, 3'b001, 32'hFFFF_8000, 1'b0, "lh_16");
        txn(0, 1, 32'h16, 32'd0, 3'b101, 32'h0000_8000, 1'b0, "lhu_16");

        // Partial stores
        txn(0, 0, 32'h20, 32'h1122_3344, 3'b010, 32'd0, 1'b0, "sw_20");
        txn(0, 0, 32'h21, 32'h0000_00AA, 3'b000, 32'd0, 1'b0, "sb_21");
        txn(0, 0, 32'h22, 32'h0000_BEEF, 3'b001, 32'd0, 1'b0, "sh_22");
        txn(0, 1, 32'h20, 32'd0, 3'b010, 32'hBEEF_AA44, 1'b0, "lw_20");

        // Errors
        txn(0, 1, 32'h13, 32'd0, 3'b010, 32'd0, 1'b1, "lw_mis");
        txn(0, 1, 32'h14, 32'd0, 3'b011, 32'd0, 1'b1, "ld_f3_011");
        txn(0, 0, 32'h30, 32'hCAFE_F00D, 3'b010, 32'd0, 1'b0, "sw_30");
        txn(0, 0, 32'h31, 32'h0000_1234, 3'b001, 32'd0, 1'b1, "sh_mis");
        txn(0, 1, 32'h30, 32'd0, 3'b010, 32'hCAFE_F00D, 1'b0, "lw_30_keep");

        // Address aliasing
        txn(0, 0, 32'h1000, 32'hA5A5_A5A5, 3'b010, 32'd0, 1'b0, "sw_1000");
        txn(0, 1, 32'h0, 32'd0, 3'b010, 32'hA5A5_A5A5, 1'b0, "lw_alias");

        // Mid-operation reset during ST_WAIT
        txn(0, 0, 32'h40, 32'h0BAD_F00D, 3'b010, 32'd0, 1'b0, "sw_40");
        @(negedge clk);
        addr = 32'h40; wdata = 32'h5555_5555; f3 = 3'b010; v0 = 1'b1;
        @(negedge clk);
        chk("mid_stwait", {29'd0, st0}, 32'd3);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_state", {29'd0, st0}, 32'd0);
        chk("mid_rst_outs", {28'd0, valid0, ready0, err0, |rdata0}, 32'd0);
        rst = 1'b1; v0 = 1'b0;
        @(negedge clk);
        chk("mid_no_ready", {31'd0, ready0}, 32'd0);
        txn(0, 1, 32'h40, 32'd0, 3'b010, 32'h0BAD_F00D, 1'b0, "lw_40_keep");

        // Load request dropped during LD_WAIT still yields one pulse
        @(negedge clk);
        addr = 32'h14; f3 = 3'b010; r0 = 1'b1;
        @(negedge clk);
        r0 = 1'b0; addr = 32'h20;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (valid0) begin
                pulses++;
                chk("drop_rdata", rdata0, 32'h8000_00F0);
            end
        end
        chk("drop_pulses", pulses, 1);

        // LATENCY=0: simultaneous requests, load first then store
        txn(1, 0, 32'h8, 32'h2468_ACE0, 3'b010, 32'd0, 1'b0, "z_sw_pre");
        @(negedge clk);
        addr = 32'h8; wdata = 32'h1357_9BDF; f3 = 3'b010; r1 = 1'b1; v1 = 1'b1;
        @(negedge clk);
        chk("z_c1_valid", {31'd0, valid1}, 32'd1);
        chk("z_c1_ready", {31'd0, ready1}, 32'd0);
        chk("z_c1_rdata", rdata1, 32'h2468_ACE0);
        r1 = 1'b0;
        @(negedge clk);
        chk("z_c2_quiet", {30'd0, valid1, ready1}, 32'd0);
        @(negedge clk);
        chk("z_c3_ready", {31'd0, ready1}, 32'd1);
        chk("z_c3_valid", {31'd0, valid1}, 32'd0);
        chk("z_c3_err", {31'd0, err1}, 32'd0);
        v1 = 1'b0;
        txn(1, 1, 32'h8, 32'd0, 3'b010, 32'h1357_9BDF, 1'b0, "z_lw_new");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
